adc_spi_reader: RTL and testbench

//  Serial front end for the motor-current ADC (12-bit, 16-clock SPI frame, 4 leading zeros).

---
 rtl/adc_spi_reader.sv | 196 +++++++++++++++++++
 tb/tb_adc_spi_reader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_reader.sv
// ---------------------------------------------------------------------------
// adc_spi_reader
//
// Serial front end for the motor-current ADC. Each rising edge of start_i
// (the PWM stage's ADC latch pulse) runs one SPI frame: cs_n_o drops, a
// setup delay of CLK_DIV cycles elapses with sclk_o high, then FRAME_BITS
// SCLK periods clock the word in MSB first. The low DATA_W bits are then
// presented on data_o in a single cycle, flagged by valid_o. A quiet gap
// with cs_n_o high follows before another request is accepted.
//
// Ports
//   clk_i    in   system clock, all logic on the rising edge
//   rst_i    in   asynchronous active-high reset, aborts any frame at once
//   start_i  in   conversion request, only 0->1 transitions count
//   sdata_i  in   ADC serial data, MSB first, changes after SCLK falls
//   cs_n_o   out  ADC chip select, active low
//   sclk_o   out  ADC serial clock, idles high
//   data_o   out  last valid conversion result, unsigned
//   valid_o  out  one-cycle pulse, data_o updated this cycle
//   err_o    out  one-cycle pulse with valid_o, a leading bit read as 1
//   busy_o   out  high from the accepted start edge until the quiet gap ends
// ---------------------------------------------------------------------------
module adc_spi_reader #(
  parameter int CLK_DIV    = 4,
  parameter int FRAME_BITS = 16,
  parameter int LEAD_BITS  = 4,
  parameter int QUIET_CYC  = 8,
  localparam int DATA_W    = FRAME_BITS - LEAD_BITS
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              sdata_i,
  output logic              cs_n_o,
  output logic              sclk_o,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              err_o,
  output logic              busy_o
);

  localparam int MAX_CNT = (CLK_DIV > QUIET_CYC) ? CLK_DIV : QUIET_CYC;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int BIT_W   = $clog2(FRAME_BITS + 1);

  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
  // The final SCLK-high half period is one cycle short so that the DONE
  // cycle completes it and valid_o lands on the documented latency.
  localparam logic [CNT_W-1:0] DIV_PRE    = CNT_W'(CLK_DIV - 2);
  localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(QUIET_CYC - 1);
  localparam logic [BIT_W-1:0] BITS_ALL   = BIT_W'(FRAME_BITS);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_QUIET = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic                  cs_n_q, cs_n_d;
  logic                  sclk_q, sclk_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;
  logic                  start_q;
  logic                  start_edge;

  // start_q resets to 1 so a request already high at reset release is not
  // mistaken for a fresh edge.
  assign start_edge = start_i & ~start_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    cs_n_d    = cs_n_q;
    sclk_d    = sclk_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    busy_d    = busy_q;

    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d   = ST_SETUP;
          cs_n_d    = 1'b0;
          busy_d    = 1'b1;
          cnt_d     = '0;
          bit_cnt_d = '0;
        end
      end

      ST_SETUP: begin
        if (cnt_q == DIV_LAST) begin
          state_d = ST_SHIFT;
          sclk_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_SHIFT: begin
        if (bit_cnt_q == BITS_ALL) begin
          // All bits captured; finish the last high half period.
          if (cnt_q == DIV_PRE) begin
            state_d = ST_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (cnt_q == DIV_LAST) begin
          cnt_d  = '0;
          sclk_d = ~sclk_q;
          // Sample on the cycle SCLK is driven high; the ADC changed the bit
          // at the preceding fall, so it has been stable a half period.
          if (!sclk_q) begin
            shift_d   = {shift_q[FRAME_BITS-2:0], sdata_i};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DONE: begin
        cs_n_d  = 1'b1;
        data_d  = shift_q[DATA_W-1:0];
        valid_d = 1'b1;
        err_d   = |shift_q[FRAME_BITS-1:DATA_W];
        state_d = ST_QUIET;
        cnt_d   = '0;
      end

      ST_QUIET: begin
        if (cnt_q == QUIET_LAST) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b1;
      data_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      start_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      cs_n_q    <= cs_n_d;
      sclk_q    <= sclk_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      start_q   <= start_i;
    end
  end

  assign cs_n_o  = cs_n_q;
  assign sclk_o  = sclk_q;
  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign err_o   = err_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_adc_spi_reader.sv
// ---------------------------------------------------------------------------
// tb_adc_spi_reader
//
// Directed sequence with random ADC words. A small ADC model shifts the
// chosen 16-bit word out on SCLK falling edges; expected results come from
// the frame rules: data = low 12 bits, err = OR of the 4 leading bits,
// valid at 1 + CLK_DIV*(1 + 2*FRAME_BITS) cycles after the start edge.
// ---------------------------------------------------------------------------
module tb_adc_spi_reader;

  localparam int CLK_DIV    = 4;
  localparam int FRAME_BITS = 16;
  localparam int LEAD_BITS  = 4;
  localparam int QUIET_CYC  = 8;
  localparam int DATA_W     = FRAME_BITS - LEAD_BITS;
  localparam int LAT        = 1 + CLK_DIV * (1 + 2 * FRAME_BITS);
  localparam int BUSY_END   = LAT + QUIET_CYC;
  localparam int WIN        = 160;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              start_i = 1'b0;
  logic              sdata_i = 1'b0;
  logic              cs_n_o;
  logic              sclk_o;
  logic [DATA_W-1:0] data_o;
  logic              valid_o;
  logic              err_o;
  logic              busy_o;

  int checks = 0;
  int errors = 0;

  logic [FRAME_BITS-1:0] adc_word = '0;
  int                    adc_idx  = 0;
  logic [DATA_W-1:0]     model_data = '0;

  adc_spi_reader #(
    .CLK_DIV   (CLK_DIV),
    .FRAME_BITS(FRAME_BITS),
    .LEAD_BITS (LEAD_BITS),
    .QUIET_CYC (QUIET_CYC)
  ) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .start_i(start_i),
    .sdata_i(sdata_i),
    .cs_n_o (cs_n_o),
    .sclk_o (sclk_o),
    .data_o (data_o),
    .valid_o(valid_o),
    .err_o  (err_o),
    .busy_o (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // ADC model: junk before the first fall, then one bit per SCLK fall.
  always @(negedge cs_n_o) begin
    adc_idx = FRAME_BITS - 1;
    sdata_i = 1'($urandom);
  end

  always @(negedge sclk_o) begin
    if (!cs_n_o && adc_idx >= 0) begin
      sdata_i = adc_word[adc_idx];
      adc_idx = adc_idx - 1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One conversion from idle. Called right after a falling clock edge.
  task automatic convert(input logic [FRAME_BITS-1:0] word, input bit retrig, input string tag);
    int valid_cnt    = 0;
    int valid_at     = -1;
    int sclk_falls   = 0;
    int sclk_low     = 0;
    int data_changes = 0;
    logic [DATA_W-1:0] prev_data = data_o;
    logic              prev_sclk = sclk_o;
    logic [DATA_W-1:0] got_data  = '0;
    logic              got_err   = 1'b0;
    logic [DATA_W-1:0] exp_data  = word[DATA_W-1:0];
    logic              exp_err   = |word[FRAME_BITS-1:DATA_W];

    adc_word = word;
    start_i  = 1'b1;
    for (int k = 1; k <= WIN; k++) begin
      @(negedge clk_i);
      if (k == 1) begin
        check({tag, "/cs_n_low"}, 32'(cs_n_o), 32'd0);
        check({tag, "/busy_set"}, 32'(busy_o), 32'd1);
      end
      if (k == BUSY_END - 1) check({tag, "/busy_last"}, 32'(busy_o), 32'd1);
      if (k == BUSY_END)     check({tag, "/busy_clear"}, 32'(busy_o), 32'd0);
      if (valid_o) begin
        valid_cnt++;
        if (valid_at < 0) begin
          valid_at = k;
          got_data = data_o;
          got_err  = err_o;
          check({tag, "/cs_n_at_valid"}, 32'(cs_n_o), 32'd1);
        end
      end else if (data_o !== prev_data) begin
        data_changes++;
      end
      prev_data = data_o;
      if (!cs_n_o && prev_sclk && !sclk_o) sclk_falls++;
      if (!cs_n_o && !sclk_o) sclk_low++;
      prev_sclk = sclk_o;
      if (k == 50) start_i = 1'b0;
      if (retrig && k == 60) start_i = 1'b1;
      if (retrig && k == 70) start_i = 1'b0;
    end
    model_data = exp_data;
    check({tag, "/valid_count"}, 32'(valid_cnt), 32'd1);
    check({tag, "/latency"}, 32'(valid_at), 32'(LAT));
    check({tag, "/data"}, 32'(got_data), 32'(exp_data));
    check({tag, "/err"}, 32'(got_err), 32'(exp_err));
    check({tag, "/sclk_periods"}, 32'(sclk_falls), 32'(FRAME_BITS));
    check({tag, "/sclk_low_cycles"}, 32'(sclk_low), 32'(FRAME_BITS * CLK_DIV));
    check({tag, "/data_stable"}, 32'(data_changes), 32'd0);
    check({tag, "/data_hold"}, 32'(data_o), 32'(model_data));
    check({tag, "/idle_cs_n"}, 32'(cs_n_o), 32'd1);
    $display("frame %s word=0x%04h data=0x%03h err=%0d latency=%0d", tag, word, got_data, got_err, valid_at);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_i);
  endtask

  initial begin
    logic [31:0] w;
    int lows;
    int vals;

    // Reset state
    idle(2);
    check("reset/cs_n", 32'(cs_n_o), 32'd1);
    check("reset/sclk", 32'(sclk_o), 32'd1);
    check("reset/data", 32'(data_o), 32'd0);
    check("reset/valid", 32'(valid_o), 32'd0);
    check("reset/err", 32'(err_o), 32'd0);
    check("reset/busy", 32'(busy_o), 32'd0);
    rst_i = 1'b0;
    idle(3);

    // 1) basic frame
    convert(16'h0ABC, 1'b0, "t1");
    // 2) back-to-back extremes, 200 cycles apart
    convert(16'h0FFF, 1'b0, "t2a");
    idle(40);
    convert(16'h0000, 1'b0, "t2b");
    // 3) second edge mid-frame is ignored; following edge is accepted
    w = $urandom;
    convert({4'h0, w[11:0]}, 1'b1, "t3a");
    w = $urandom;
    convert({4'h0, w[11:0]}, 1'b0, "t3b");
    // 4) leading bit set
    convert(16'h8123, 1'b0, "t4");

    // 5) reset during SCLK period 8
    adc_word = 16'h0555;
    start_i  = 1'b1;
    idle(4 + 8 * 7 + 2);
    rst_i = 1'b1;
    #1;
    check("t5/cs_n", 32'(cs_n_o), 32'd1);
    check("t5/sclk", 32'(sclk_o), 32'd1);
    check("t5/data", 32'(data_o), 32'd0);
    check("t5/valid", 32'(valid_o), 32'd0);
    check("t5/busy", 32'(busy_o), 32'd0);
    model_data = '0;
    start_i = 1'b0;
    idle(3);
    rst_i = 1'b0;
    vals = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (valid_o) vals++;
    end
    check("t5/no_valid", 32'(vals), 32'd0);
    check("t5/data_after", 32'(data_o), 32'(model_data));
    $display("frame t5 reset abort valid_pulses=%0d data=0x%03h", vals, data_o);
    w = $urandom;
    convert(w[15:0] & 16'h0FFF, 1'b0, "t5b");

    // Random words, some with leading bits set
    for (int n = 0; n < 4; n++) begin
      w = $urandom;
      if (w[16]) w[15:12] = 4'h0;
      convert(w[15:0], 1'b0, $sformatf("rnd%0d", n));
      idle(int'($urandom_range(0, 20)));
    end

    // 6) start held high through reset release
    rst_i   = 1'b1;
    start_i = 1'b1;
    idle(3);
    rst_i = 1'b0;
    lows = 0;
    vals = 0;
    for (int i = 0; i < WIN; i++) begin
      @(negedge clk_i);
      if (!cs_n_o) lows++;
      if (valid_o || busy_o) vals++;
    end
    check("t6/no_cs", 32'(lows), 32'd0);
    check("t6/no_activity", 32'(vals), 32'd0);
    $display("frame t6 start held through reset cs_low_cycles=%0d", lows);
    start_i = 1'b0;
    idle(2);
    w = $urandom;
    convert(w[15:0], 1'b0, "t6b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
